// File: rtl/omsp_spm_table.sv
// omsp_spm_table: multi-slot protected-module (SPM) table for openMSP430.
//
// Holds up to NUM_SPMS SPM configurations. Each configuration has a public range,
// a secret range and an ID. Every cycle, each bus access and each PC change is
// checked against all enabled slots. A create command runs a sequential scan:
// it looks at one slot per cycle, checks for range overlap and picks the first
// free slot. A disable command removes the slot that is executing and takes one
// cycle.
//
// Ports:
//   mclk, puc_rst         clock (rising edge), asynchronous active-high reset
//   pc, prev_pc           current PC and PC of the previous instruction
//   mab, mb_en, mb_wr     memory address, access strobe, byte write enables
//   cmd_valid/op/ready    command handshake (op 0 = create, 1 = disable)
//   r12..r15              pub_start, pub_end, sec_start, sec_end for create
//   rsp_valid/ok/id       one-cycle completion pulse, status, assigned/removed ID
//   violation             combinational protection violation
//   executing, exec_id    pc lies inside an enabled public range, and that slot's ID

module omsp_spm_table #(
    parameter int unsigned NUM_SPMS = 4,
    parameter int unsigned SLOT_W   = 2,
    parameter int unsigned ID_W     = 16
) (
    input  logic            mclk,
    input  logic            puc_rst,
    input  logic [15:0]     pc,
    input  logic [15:0]     prev_pc,
    input  logic [15:0]     mab,
    input  logic            mb_en,
    input  logic [1:0]      mb_wr,
    input  logic            cmd_valid,
    input  logic            cmd_op,
    output logic            cmd_ready,
    input  logic [15:0]     r12,
    input  logic [15:0]     r13,
    input  logic [15:0]     r14,
    input  logic [15:0]     r15,
    output logic            rsp_valid,
    output logic            rsp_ok,
    output logic [ID_W-1:0] rsp_id,
    output logic            violation,
    output logic            executing,
    output logic [ID_W-1:0] exec_id
);

    typedef enum logic [1:0] {StIdle, StScan, StCommit, StResp} state_e;

    // Half-open range membership: s <= a < e.
    function automatic logic f_in(input logic [15:0] a, input logic [15:0] s,
                                  input logic [15:0] e);
        return (a >= s) && (a < e);
    endfunction

    // Two half-open ranges intersect.
    function automatic logic f_ovl(input logic [15:0] as, input logic [15:0] ae,
                                   input logic [15:0] bs, input logic [15:0] be);
        return (as < be) && (ae > bs);
    endfunction

    state_e r_state, w_state_d;

    // Slot storage
    logic [NUM_SPMS-1:0] r_en;
    logic [15:0]         r_pub_start [NUM_SPMS];
    logic [15:0]         r_pub_end   [NUM_SPMS];
    logic [15:0]         r_sec_start [NUM_SPMS];
    logic [15:0]         r_sec_end   [NUM_SPMS];
    logic [ID_W-1:0]     r_id        [NUM_SPMS];

    // Latched create request and scan bookkeeping
    logic [15:0]     r_new_pub_start, r_new_pub_end, r_new_sec_start, r_new_sec_end;
    logic [SLOT_W-1:0] r_idx, r_free_idx;
    logic            r_ovl, r_free_found;
    logic [ID_W-1:0] r_id_ctr;
    logic            r_rsp_ok;
    logic [ID_W-1:0] r_rsp_id;

    logic                w_accept, w_last, w_scan_ovl, w_ok;
    logic [ID_W-1:0]     w_id_inc, w_id_next;
    logic                w_is_wr, w_busy;
    logic [NUM_SPMS-1:0] w_exec_s, w_pubacc, w_secacc, w_slot_v;
    logic                w_hit;
    logic [SLOT_W-1:0]   w_hit_idx;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    assign w_last = (r_idx == SLOT_W'(NUM_SPMS - 1));

    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (r_state)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept  = 1'b1;
                    w_state_d = cmd_op ? StResp : StScan;
                end
            end
            StScan: begin
                if (w_last) begin
                    w_state_d = StCommit;
                end
            end
            StCommit: w_state_d = StResp;
            StResp: begin
                rsp_valid = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-slot protection checks
    // ------------------------------------------------------------------
    always_comb begin
        w_is_wr  = |mb_wr;
        w_busy   = (r_state == StScan) || (r_state == StCommit);
        w_exec_s = '0;
        w_pubacc = '0;
        w_secacc = '0;
        w_slot_v = '0;
        for (int i = 0; i < NUM_SPMS; i++) begin
            w_exec_s[i] = r_en[i] & f_in(pc, r_pub_start[i], r_pub_end[i]);
            // Public-range reads are not checked while a create is in flight.
            w_pubacc[i] = r_en[i] & mb_en & f_in(mab, r_pub_start[i], r_pub_end[i])
                          & ~(w_busy & ~w_is_wr);
            w_secacc[i] = r_en[i] & mb_en & f_in(mab, r_sec_start[i], r_sec_end[i]);
            w_slot_v[i] = (w_pubacc[i] & ~(w_exec_s[i] & ~w_is_wr))
                        | (w_secacc[i] & ~w_exec_s[i])
                        | (w_exec_s[i] & ~f_in(prev_pc, r_pub_start[i], r_pub_end[i])
                           & (pc != r_pub_start[i]));
        end
    end

    assign violation = |w_slot_v;

    // Lowest-index executing slot wins; the loop runs downwards so the last hit is the lowest.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = int'(NUM_SPMS) - 1; i >= 0; i--) begin
            if (w_exec_s[i]) begin
                w_hit     = 1'b1;
                w_hit_idx = SLOT_W'(i);
            end
        end
    end

    assign executing = w_hit;
    assign exec_id   = w_hit ? r_id[w_hit_idx] : '0;

    // ------------------------------------------------------------------
    // Create evaluation
    // ------------------------------------------------------------------
    assign w_scan_ovl = r_en[r_idx] & (
          f_ovl(r_new_pub_start, r_new_pub_end, r_pub_start[r_idx], r_pub_end[r_idx])
        | f_ovl(r_new_pub_start, r_new_pub_end, r_sec_start[r_idx], r_sec_end[r_idx])
        | f_ovl(r_new_sec_start, r_new_sec_end, r_pub_start[r_idx], r_pub_end[r_idx])
        | f_ovl(r_new_sec_start, r_new_sec_end, r_sec_start[r_idx], r_sec_end[r_idx]));

    assign w_ok = (r_new_pub_start < r_new_pub_end) & (r_new_sec_start <= r_new_sec_end)
                & ~f_ovl(r_new_pub_start, r_new_pub_end, r_new_sec_start, r_new_sec_end)
                & ~r_ovl & r_free_found;

    // ID 0 means "none", so the counter skips it when it wraps.
    assign w_id_inc  = r_id_ctr + ID_W'(1);
    assign w_id_next = (w_id_inc == '0) ? ID_W'(1) : w_id_inc;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_en            <= '0;
            r_new_pub_start <= '0;
            r_new_pub_end   <= '0;
            r_new_sec_start <= '0;
            r_new_sec_end   <= '0;
            r_idx           <= '0;
            r_free_idx      <= '0;
            r_ovl           <= 1'b0;
            r_free_found    <= 1'b0;
            r_id_ctr        <= ID_W'(1);
            r_rsp_ok        <= 1'b0;
            r_rsp_id        <= '0;
            for (int i = 0; i < NUM_SPMS; i++) begin
                r_pub_start[i] <= '0;
                r_pub_end[i]   <= '0;
                r_sec_start[i] <= '0;
                r_sec_end[i]   <= '0;
                r_id[i]        <= '0;
            end
        end else begin
            if (w_accept) begin
                r_new_pub_start <= r12;
                r_new_pub_end   <= r13;
                r_new_sec_start <= r14;
                r_new_sec_end   <= r15;
                r_idx           <= '0;
                r_free_idx      <= '0;
                r_ovl           <= 1'b0;
                r_free_found    <= 1'b0;
                if (cmd_op) begin
                    // Disable acts on the slot executing at the accept edge.
                    r_rsp_ok <= w_hit;
                    r_rsp_id <= w_hit ? r_id[w_hit_idx] : '0;
                    if (w_hit) begin
                        r_en[w_hit_idx]        <= 1'b0;
                        r_pub_start[w_hit_idx] <= '0;
                        r_pub_end[w_hit_idx]   <= '0;
                        r_sec_start[w_hit_idx] <= '0;
                        r_sec_end[w_hit_idx]   <= '0;
                        r_id[w_hit_idx]        <= '0;
                    end
                end
            end

            if (r_state == StScan) begin
                if (w_scan_ovl) begin
                    r_ovl <= 1'b1;
                end
                if (!r_en[r_idx] && !r_free_found) begin
                    r_free_found <= 1'b1;
                    r_free_idx   <= r_idx;
                end
                if (!w_last) begin
                    r_idx <= r_idx + SLOT_W'(1);
                end
            end

            if (r_state == StCommit) begin
                r_rsp_ok <= w_ok;
                r_rsp_id <= w_ok ? r_id_ctr : '0;
                if (w_ok) begin
                    r_en[r_free_idx]        <= 1'b1;
                    r_pub_start[r_free_idx] <= r_new_pub_start;
                    r_pub_end[r_free_idx]   <= r_new_pub_end;
                    r_sec_start[r_free_idx] <= r_new_sec_start;
                    r_sec_end[r_free_idx]   <= r_new_sec_end;
                    r_id[r_free_idx]        <= r_id_ctr;
                    r_id_ctr                <= w_id_next;
                end
            end
        end
    end

    assign rsp_ok = r_rsp_ok;
    assign rsp_id = r_rsp_id;

endmodule

// File: tb/tb_omsp_spm_table.sv
// Directed testbench for omsp_spm_table with hand-computed expected values.
module tb_omsp_spm_table;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic [15:0] pc, prev_pc, mab;
    logic        mb_en;
    logic [1:0]  mb_wr;
    logic        cmd_valid, cmd_op, cmd_ready;
    logic [15:0] r12, r13, r14, r15;
    logic        rsp_valid, rsp_ok;
    logic [15:0] rsp_id;
    logic        violation, executing;
    logic [15:0] exec_id;

    int n_checks = 0;
    int n_errors = 0;

    omsp_spm_table #(
        .NUM_SPMS (4),
        .SLOT_W   (2),
        .ID_W     (16)
    ) u_dut (
        .mclk      (mclk),
        .puc_rst   (puc_rst),
        .pc        (pc),
        .prev_pc   (prev_pc),
        .mab       (mab),
        .mb_en     (mb_en),
        .mb_wr     (mb_wr),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .r12       (r12),
        .r13       (r13),
        .r14       (r14),
        .r15       (r15),
        .rsp_valid (rsp_valid),
        .rsp_ok    (rsp_ok),
        .rsp_id    (rsp_id),
        .violation (violation),
        .executing (executing),
        .exec_id   (exec_id)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic send_cmd(input string tag, input logic op, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
        check({tag, "_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        r12 = a; r13 = b; r14 = c; r15 = d;
        step();
        cmd_valid = 1'b0;
    endtask

    // Latency is the edge (counted from the accept edge) at which rsp_valid is sampled high.
    task automatic wait_rsp(input string tag, input int exp_lat, input logic exp_ok,
                            input logic [15:0] exp_id);
        int cnt = 0;
        while (!rsp_valid && cnt < 20) begin
            step();
            cnt++;
        end
        check({tag, "_lat"}, cnt + 1, exp_lat);
        check({tag, "_ok"}, rsp_ok, exp_ok);
        check({tag, "_id"}, rsp_id, exp_id);
        step();
        check({tag, "_pulse"}, rsp_valid, 0);
    endtask

    task automatic create(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d,
                          input logic exp_ok, input logic [15:0] exp_id);
        send_cmd(tag, 1'b0, a, b, c, d);
        wait_rsp(tag, 6, exp_ok, exp_id);
    endtask

    task automatic disable_spm(input string tag, input logic [15:0] pcv,
                               input logic exp_ok, input logic [15:0] exp_id);
        pc = pcv;
        prev_pc = pcv;
        send_cmd(tag, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
        wait_rsp(tag, 1, exp_ok, exp_id);
        pc = 16'h7000;
        prev_pc = 16'h7000;
    endtask

    task automatic probe(input string tag, input logic [15:0] pcv, input logic [15:0] prevv,
                         input logic en, input logic [15:0] mabv, input logic [1:0] wr,
                         input logic exp_v, input logic exp_ex, input logic [15:0] exp_id);
        pc = pcv; prev_pc = prevv; mb_en = en; mab = mabv; mb_wr = wr;
        #1;
        check({tag, "_viol"}, violation, exp_v);
        check({tag, "_exec"}, executing, exp_ex);
        check({tag, "_xid"}, exec_id, exp_id);
    endtask

    initial begin
        int rsp_seen;
        puc_rst = 1'b1;
        pc = 16'h7000; prev_pc = 16'h7000; mab = 16'h0; mb_en = 1'b0; mb_wr = 2'b00;
        cmd_valid = 1'b0; cmd_op = 1'b0;
        r12 = 16'h0; r13 = 16'h0; r14 = 16'h0; r15 = 16'h0;
        repeat (2) @(posedge mclk);
        #1;
        puc_rst = 1'b0;
        step();
        check("rst_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_ok", rsp_ok, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_viol", violation, 0);
        check("rst_exec", executing, 0);
        check("rst_exec_id", exec_id, 0);

        create("cr_a", 16'h8000, 16'h8100, 16'h0200, 16'h0280, 1'b1, 16'd1);
        create("cr_b", 16'h9000, 16'h9100, 16'h0300, 16'h0380, 1'b1, 16'd2);

        probe("entry_mid",   16'h8010, 16'h7000, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 16'd1);
        probe("entry_start", 16'h8000, 16'h7000, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 16'd1);
        probe("inside",      16'h8010, 16'h8000, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 16'd1);
        probe("sec_rd_out",  16'h7000, 16'h7000, 1'b1, 16'h0240, 2'b00, 1'b1, 1'b0, 16'd0);
        probe("sec_rd_in",   16'h8010, 16'h8000, 1'b1, 16'h0240, 2'b00, 1'b0, 1'b1, 16'd1);
        probe("pub_wr_in",   16'h8010, 16'h8000, 1'b1, 16'h8004, 2'b01, 1'b1, 1'b1, 16'd1);
        probe("pub_rd_in",   16'h8010, 16'h8000, 1'b1, 16'h8004, 2'b00, 1'b0, 1'b1, 16'd1);
        probe("pub_rd_out",  16'h7000, 16'h7000, 1'b1, 16'h8004, 2'b00, 1'b1, 1'b0, 16'd0);
        probe("pub_end",     16'h7000, 16'h7000, 1'b1, 16'h8100, 2'b00, 1'b0, 1'b0, 16'd0);
        probe("sec_last",    16'h7000, 16'h7000, 1'b1, 16'h027F, 2'b00, 1'b1, 1'b0, 16'd0);
        probe("sec_end",     16'h7000, 16'h7000, 1'b1, 16'h0280, 2'b00, 1'b0, 1'b0, 16'd0);
        probe("cross_sec",   16'h8010, 16'h8000, 1'b1, 16'h0340, 2'b00, 1'b1, 1'b1, 16'd1);
        probe("slot1_exec",  16'h9000, 16'h7000, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 16'd2);
        probe("no_strobe",   16'h7000, 16'h7000, 1'b0, 16'h0240, 2'b00, 1'b0, 1'b0, 16'd0);

        create("cr_ovl", 16'h80F0, 16'h8200, 16'h0400, 16'h0480, 1'b0, 16'd0);

        // Empty public range; public reads are exempt while the scan is running.
        send_cmd("cr_empty", 1'b0, 16'hD000, 16'hD000, 16'h0400, 16'h0480);
        mb_en = 1'b1; mab = 16'h8004; mb_wr = 2'b00;
        #1;
        check("scan_pub_rd", violation, 0);
        mb_wr = 2'b01;
        #1;
        check("scan_pub_wr", violation, 1);
        mb_en = 1'b0; mb_wr = 2'b00;
        wait_rsp("cr_empty", 6, 1'b0, 16'd0);

        create("cr_self", 16'hD000, 16'hD100, 16'hD080, 16'hD200, 1'b0, 16'd0);
        create("cr_c", 16'hA000, 16'hA100, 16'h0500, 16'h0580, 1'b1, 16'd3);
        create("cr_d", 16'hB000, 16'hB100, 16'h0600, 16'h0680, 1'b1, 16'd4);
        create("cr_full", 16'hC000, 16'hC100, 16'h0700, 16'h0780, 1'b0, 16'd0);

        disable_spm("dis_a", 16'h8010, 1'b1, 16'd1);
        probe("after_dis", 16'h8010, 16'h8010, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 16'd0);
        create("cr_reuse", 16'hC000, 16'hC100, 16'h0700, 16'h0780, 1'b1, 16'd5);
        probe("reuse_exec", 16'hC000, 16'h7000, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 16'd5);
        disable_spm("dis_none", 16'h7000, 1'b0, 16'd0);

        // Reset in the middle of a scan.
        send_cmd("cr_rst", 1'b0, 16'hE000, 16'hE100, 16'h0800, 16'h0880);
        step();
        puc_rst = 1'b1;
        #1;
        check("midrst_ready", cmd_ready, 1);
        check("midrst_rsp_valid", rsp_valid, 0);
        probe("midrst_exec", 16'h9000, 16'h7000, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 16'd0);
        probe("midrst_sec", 16'h7000, 16'h7000, 1'b1, 16'h0240, 2'b00, 1'b0, 1'b0, 16'd0);
        mb_en = 1'b0;
        step();
        puc_rst = 1'b0;
        rsp_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid) rsp_seen++;
        end
        check("midrst_no_rsp", rsp_seen, 0);
        create("cr_post", 16'h8000, 16'h8100, 16'h0200, 16'h0280, 1'b1, 16'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
